imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Pipelined, parametrised immediate-extension unit for the pipelined core's decode stage. It extends the 24-bit instruction immediate field to a WIDTH-bit operand in one of three modes:
- ARM data-processing rotated imm8, with shifter carry-out.
- 12-bit unsigned memory offset.
- Signed, word-shifted 24-bit branch offset.

Results are delivered through a valid/ready handshake with a two-entry skid buffer, so decode back-pressure never drops or duplicates an immediate.

## Interface
Parameters:
- WIDTH, 32, output operand width; legal range 32..64; all modes zero- or sign-extend to WIDTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has an immediate request.
- in_ready  out  1  unit can accept a request this cycle.
- ImmSrc  in  2  mode: 00 DP rotated imm8, 01 imm12 unsigned, 10 branch imm24, 11 reserved.
- Extend_in  in  24  instruction bits [23:0].
- carry_in  in  1  current CPSR C flag, used when the rotation is zero.
- out_valid  out  1  ExtImm/ExtCarry/ext_err are valid.
- out_ready  in  1  downstream consumes the output this cycle.
- ExtImm  out  WIDTH  extended immediate.
- ExtCarry  out  1  shifter carry-out for mode 00; carry_in passthrough otherwise.
- ext_err  out  1  request used reserved mode 11.

## Operation
- An accept occurs when in_valid && in_ready. The extension is computed combinationally from that cycle's inputs and captured into the buffer.
- Mode 00 (with IMM_ROTATE_EN):
  - imm8 = Extend_in[7:0], rot = Extend_in[11:8].
  - r32 = imm8 zero-extended to 32 bits, rotated right by 2*rot within 32 bits.
  - ExtImm = r32 zero-extended to WIDTH.
  - ExtCarry = carry_in if rot==0, else r32[31].
- Mode 01: ExtImm = zero-extend Extend_in[11:0]; ExtCarry = carry_in.
- Mode 10: ExtImm = sign-extend {Extend_in[23:0], 2'b00} to WIDTH (bit 25 replicated); ExtCarry = carry_in.
- Mode 11: ExtImm = 0, ExtCarry = carry_in, ext_err = 1. No X is ever driven. ext_err = 0 in every other mode.
- Buffer: an output register (slot O) plus one skid register (slot S). Order is strictly FIFO.
  - Accept with O empty, or with O draining this cycle: data goes to O.
  - Accept with O full and not draining: data goes to S.
  - When O drains and S is full: S moves to O.
- Boundary conditions:
  - Simultaneous accept and drain with both slots full cannot occur, because in_ready is low.
  - Simultaneous accept and drain with only O full: O takes the new data and S stays empty.
  - Output fields are held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle. A request accepted at edge N appears with out_valid=1 after edge N.
- Throughput: 1 per cycle while out_ready stays high.
- in_ready = !S_full. It is a pure register output with no combinational path from out_ready.
- Reset values:
  - out_valid=0 and both slots empty.
  - ExtImm=0, ExtCarry=0, ext_err=0.
  - in_ready=0 while reset is high and 1 on the first cycle after reset.
- Reset asserted mid-stream discards both slots. out_valid=0 after the next edge; no partial output appears.

## Configuration
- IMM_ROTATE_EN defined: mode 00 performs the rotate and carry generation described above.
- Undefined: mode 00 gives ExtImm = zero-extend Extend_in[7:0] and ExtCarry = carry_in. Extend_in[11:8] is ignored and no rotator is synthesised.

## Structure
- Shared package/header imm_pkg holds the ImmSrc encodings IMM_DP8=2'b00, IMM_MEM12=2'b01, IMM_BR24=2'b10, IMM_RSVD=2'b11, and the payload width constant (WIDTH+2 bits: ExtImm, ExtCarry, ext_err).
- One sub-module: skid_buffer, parametrised on payload width, containing the O/S slots and the handshake. Extension logic stays in imm_extend_pipe.

## Test plan
- ImmSrc=00, Extend_in=24'h0004FF, carry_in=0:
  - With IMM_ROTATE_EN: ExtImm=32'hFF000000, ExtCarry=1.
  - Without it: ExtImm=32'h000000FF, ExtCarry=0.
  - With Extend_in=24'h0000FF and carry_in=1 (rot=0): ExtCarry=1.
- ImmSrc=01, Extend_in=24'hFFFABC, carry_in=1: ExtImm=32'h00000ABC, ExtCarry=1.
- ImmSrc=10:
  - Extend_in=24'hFFFFFF: ExtImm=32'hFFFFFFFC.
  - Extend_in=24'h000001: ExtImm=32'h00000004.
  - With WIDTH=64 and 24'h800000: ExtImm=64'hFFFFFFFFFE000000.
- ImmSrc=11: ExtImm=0, ext_err=1. A following mode-01 request gives ext_err=0.
- Back-pressure:
  - Set out_ready=0 and send A and B on consecutive cycles: in_ready drops after B, and A stays stable on the output.
  - Raise out_ready: A, then B are delivered on consecutive cycles, and in_ready returns to 1.
- Assert reset with both slots full: out_valid=0 after one edge, and nothing from before the reset is ever emitted.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared encodings for the immediate-extension pipe: ImmSrc modes, skid-buffer
// occupancy states and the payload width helper.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_DP8   = 2'b00,
        IMM_MEM12 = 2'b01,
        IMM_BR24  = 2'b10,
        IMM_RSVD  = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;

    // Payload is {ExtImm, ExtCarry, ext_err}.
    function automatic int unsigned payload_width(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_skid_buffer.sv
// Two-entry FIFO skid buffer (output slot O plus skid slot S) with a
// registered in_ready that has no combinational path from out_ready.
module skid_buffer
    import imm_pkg::*;
#(
    parameter int unsigned W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    occ_e         state, state_next;
    logic         rdy_q;
    logic [W-1:0] o_q, s_q;
    logic         accept, drain;
    logic         load_o, load_o_from_s, load_s;

    assign in_ready  = rdy_q;
    assign out_valid = (state != OCC_EMPTY);
    assign out_data  = o_q;
    assign accept    = in_valid && rdy_q;
    assign drain     = (state != OCC_EMPTY) && out_ready;

    always_comb begin
        state_next    = state;
        load_o        = 1'b0;
        load_o_from_s = 1'b0;
        load_s        = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    state_next = OCC_ONE;
                    load_o     = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    load_o = 1'b1;
                end else if (accept) begin
                    state_next = OCC_TWO;
                    load_s     = 1'b1;
                end else if (drain) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    state_next    = OCC_ONE;
                    load_o_from_s = 1'b1;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OCC_EMPTY;
            rdy_q <= 1'b0;
            o_q   <= '0;
            s_q   <= '0;
        end else begin
            state <= state_next;
            rdy_q <= (state_next != OCC_TWO);
            if (load_o) begin
                o_q <= in_data;
            end else if (load_o_from_s) begin
                o_q <= s_q;
            end
            if (load_s) begin
                s_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Decode-stage immediate extension (DP rotated imm8, imm12, branch imm24)
// behind a skid buffer. Define IMM_ROTATE_EN to enable the mode-00 rotator.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ImmSrc,
    input  logic [23:0]      Extend_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ExtImm,
    output logic             ExtCarry,
    output logic             ext_err
);

    localparam int unsigned PW = payload_width(WIDTH);

    logic [WIDTH-1:0] ext_imm;
    logic             ext_carry;
    logic             ext_e;
    logic [PW-1:0]    pay_in, pay_out;

`ifdef IMM_ROTATE_EN
    logic [4:0]  rot_sh;
    logic [63:0] rot_dbl;
    logic [31:0] r32;

    // Right-rotate by shifting a doubled copy; the low word is the rotation.
    assign rot_sh  = {Extend_in[11:8], 1'b0};
    assign rot_dbl = {24'b0, Extend_in[7:0], 24'b0, Extend_in[7:0]} >> rot_sh;
    assign r32     = rot_dbl[31:0];
`endif

    always_comb begin
        ext_imm   = '0;
        ext_carry = carry_in;
        ext_e     = 1'b0;
        case (imm_src_e'(ImmSrc))
            IMM_DP8: begin
`ifdef IMM_ROTATE_EN
                ext_imm[31:0] = r32;
                if (Extend_in[11:8] != 4'd0) begin
                    ext_carry = r32[31];
                end
`else
                ext_imm[7:0] = Extend_in[7:0];
`endif
            end
            IMM_MEM12: ext_imm = WIDTH'(Extend_in[11:0]);
            IMM_BR24:  ext_imm = WIDTH'($signed({Extend_in, 2'b00}));
            IMM_RSVD:  ext_e   = 1'b1;
            default:   ext_e   = 1'b1;
        endcase
    end

    assign pay_in = {ext_imm, ext_carry, ext_e};

    skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign ExtImm   = pay_out[PW-1:2];
    assign ExtCarry = pay_out[1];
    assign ext_err  = pay_out[0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised and directed self-checking bench for imm_extend_pipe, checked
// against a FIFO-of-expected-results reference model.
module tb_imm_extend_pipe;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ImmSrc;
    logic [23:0]   Extend_in;
    logic          carry_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ExtImm;
    logic          ExtCarry;
    logic          ext_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        logic [63:0] imm;
        logic        c;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    imm_extend_pipe #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ImmSrc   (ImmSrc),
        .Extend_in(Extend_in),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ExtImm   (ExtImm),
        .ExtCarry (ExtCarry),
        .ext_err  (ext_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] src, input logic [23:0] e, input logic cin);
        exp_t        r;
        logic [63:0] mask;
        logic [63:0] v;
        int unsigned sh;
        longint      s;
        mask  = (W >= 64) ? '1 : ((64'd1 << W) - 64'd1);
        r.imm = '0;
        r.c   = cin;
        r.e   = 1'b0;
        case (src)
            2'b00: begin
`ifdef IMM_ROTATE_EN
                sh    = 2 * int'(e[11:8]);
                v     = 64'(e[7:0]);
                r.imm = ((v >> sh) | (v << (32 - sh))) & 64'hFFFF_FFFF;
                if (sh != 0) r.c = r.imm[31];
`else
                r.imm = 64'(e[7:0]);
`endif
            end
            2'b01: r.imm = 64'(e) % 64'd4096;
            2'b10: begin
                s     = longint'($signed(e)) * 4;
                r.imm = 64'(s) & mask;
            end
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    // One clock cycle: apply inputs, check outputs against the model FIFO, advance.
    task automatic cycle(input logic iv, input logic [1:0] src, input logic [23:0] e,
                         input logic cin, input logic ordy);
        exp_t front;
        logic acc, drn;
        in_valid  = iv;
        ImmSrc    = src;
        Extend_in = e;
        carry_in  = cin;
        out_ready = ordy;
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        if (out_valid && exp_q.size() != 0) begin
            front = exp_q[0];
            check_eq("ExtImm", 64'(ExtImm), front.imm);
            check_eq("ExtCarry", 64'(ExtCarry), 64'(front.c));
            check_eq("ext_err", 64'(ext_err), 64'(front.e));
        end
        acc = iv && in_ready;
        drn = out_valid && ordy;
        if (drn && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(model(src, e, cin));
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [1:0] src, input logic [23:0] e,
                            input logic cin, input logic [63:0] imm, input logic c,
                            input logic err);
        drain_all();
        cycle(1'b1, src, e, cin, 1'b1);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_imm"}, 64'(ExtImm), imm);
        check_eq({tag, "_carry"}, 64'(ExtCarry), 64'(c));
        check_eq({tag, "_err"}, 64'(ext_err), 64'(err));
        cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        ImmSrc    = 2'b00;
        Extend_in = '0;
        carry_in  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_ExtImm", 64'(ExtImm), 64'd0);
        check_eq("rst_ExtCarry", 64'(ExtCarry), 64'd0);
        check_eq("rst_ext_err", 64'(ext_err), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef IMM_ROTATE_EN
        directed("dp_rot", 2'b00, 24'h0004FF, 1'b0, 64'hFF000000, 1'b1, 1'b0);
`else
        directed("dp_plain", 2'b00, 24'h0004FF, 1'b0, 64'h000000FF, 1'b0, 1'b0);
`endif
        directed("dp_rot0", 2'b00, 24'h0000FF, 1'b1, 64'h000000FF, 1'b1, 1'b0);
        directed("mem12", 2'b01, 24'hFFFABC, 1'b1, 64'h00000ABC, 1'b1, 1'b0);
        directed("br_neg", 2'b10, 24'hFFFFFF, 1'b0, 64'hFFFFFFFC, 1'b0, 1'b0);
        directed("br_pos", 2'b10, 24'h000001, 1'b1, 64'h00000004, 1'b1, 1'b0);
        directed("br_min", 2'b10, 24'h800000, 1'b0, 64'hFE000000, 1'b0, 1'b0);
        directed("rsvd", 2'b11, 24'hABCDEF, 1'b1, 64'h0, 1'b1, 1'b1);
        directed("after_rsvd", 2'b01, 24'h000123, 1'b0, 64'h00000123, 1'b0, 1'b0);

        // Back-pressure: A and B queued, A held, then both delivered in order.
        drain_all();
        cycle(1'b1, 2'b01, 24'h000AAA, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 24'h000BBB, 1'b1, 1'b0);
        check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
        cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b0);
        check_eq("bp_hold_A", 64'(ExtImm), 64'h00000AAA);
        cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b1);
        check_eq("bp_then_B", 64'(ExtImm), 64'h00000BBB);
        cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b1);
        check_eq("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Reset with both slots full discards everything.
        cycle(1'b1, 2'b10, 24'h123456, 1'b0, 1'b0);
        cycle(1'b1, 2'b10, 24'h654321, 1'b0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 24'h0, 1'b0, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 24'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
